// File: rtl/midi_pkg.sv
// Shared message type and helpers for the button-to-MIDI note path.
package midi_pkg;

   typedef struct packed {
      logic [7:0] status;
      logic [7:0] data1;
      logic [7:0] data2;
   } midi_msg_t;

   localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
   localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;

   function automatic midi_msg_t make_note_msg(input logic       note_on,
                                               input logic [3:0] chan,
                                               input logic [7:0] note,
                                               input logic [7:0] vel);
      midi_msg_t m;
      m.status = {(note_on ? MIDI_NOTE_ON : MIDI_NOTE_OFF), chan};
      m.data1  = {1'b0, note[6:0]};
      m.data2  = note_on ? {1'b0, vel[6:0]} : 8'h00;
      return m;
   endfunction

endpackage

// File: rtl/midi_note_gen_debounce.sv
// Per-button 2-flop synchronizer and stability counter producing a debounced level
// plus single-cycle rise/fall strobes that coincide with the debounced update edge.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CNT = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int unsigned CNT_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

   logic             sync1;
   logic             sync2;
   logic             state;
   logic [CNT_W-1:0] cnt;
   logic             settle;

   // With a 1-bit level, any change of the synced value while it differs from the
   // debounced state makes it equal again, so the equality test also covers bounce.
   assign settle = (sync2 != state) && (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         state <= 1'b0;
         cnt   <= '0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         if (sync2 == state) begin
            cnt <= '0;
         end else if (settle) begin
            state <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   assign level = state;
   assign rise  = settle &  sync2;
   assign fall  = settle & ~sync2;

endmodule

// File: rtl/midi_note_gen.sv
// Debounced buttons -> pending Note-On/Off flags -> fixed-priority arbiter -> message FIFO
// offered to the MIDI serializer on a valid/ready interface.
module midi_note_gen
   import midi_pkg::*;
#(
   parameter int unsigned N_BTN        = 4,
   parameter int unsigned DEBOUNCE_CNT = 1_000_000,
   parameter int unsigned CHANNEL      = 0,
   parameter int unsigned BASE_NOTE    = 60,
   parameter int unsigned VELOCITY     = 100,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn,
   output logic             msg_valid,
   input  logic             msg_ready,
   output logic [7:0]       msg_status,
   output logic [7:0]       msg_data1,
   output logic [7:0]       msg_data2,
   output logic             busy
);

   localparam int unsigned PW   = $clog2(FIFO_DEPTH);
   localparam int unsigned CW   = PW + 1;
   localparam int unsigned IDXW = (N_BTN > 1) ? $clog2(N_BTN) : 1;

   if (N_BTN < 1 || N_BTN > 8 || DEBOUNCE_CNT < 1 || CHANNEL > 15 ||
       BASE_NOTE + N_BTN - 1 > 127 || VELOCITY < 1 || VELOCITY > 127 ||
       FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_err
      $error("midi_note_gen: parameter out of range");
   end

   logic [N_BTN-1:0] db_level;
   logic [N_BTN-1:0] db_rise;
   logic [N_BTN-1:0] db_fall;

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      btn_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db (
         .clk   (clk),
         .rst   (rst),
         .btn   (btn[i]),
         .level (db_level[i]),
         .rise  (db_rise[i]),
         .fall  (db_fall[i])
      );
   end

   logic [N_BTN-1:0] pend_on;
   logic [N_BTN-1:0] pend_off;
   logic [N_BTN-1:0] pend_on_nxt;
   logic [N_BTN-1:0] pend_off_nxt;
   logic [N_BTN-1:0] grant;
   logic [N_BTN-1:0] served;
   logic [N_BTN-1:0] on_evt;
   logic [N_BTN-1:0] off_evt;
   logic [IDXW-1:0]  sel_idx;
   logic             sel_found;
   logic             sel_on;

   midi_msg_t        mem [FIFO_DEPTH];
   logic [PW-1:0]    head;
   logic [PW-1:0]    tail;
   logic [CW-1:0]    count;
   logic             full;
   logic             push;
   logic             pop;
   midi_msg_t        push_msg;
   midi_msg_t        head_msg;

   // The debounced level is still the old value on the update edge.
   assign on_evt  = (db_rise | db_fall) & ~db_level;
   assign off_evt = (db_rise | db_fall) &  db_level;

   always_comb begin
      grant     = '0;
      sel_idx   = '0;
      sel_found = 1'b0;
      sel_on    = 1'b0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
         if (!sel_found && (pend_on[i] || pend_off[i])) begin
            grant[i]  = 1'b1;
            sel_idx   = IDXW'(i);
            sel_found = 1'b1;
            sel_on    = pend_on[i];
         end
      end
   end

   assign full     = (count == CW'(FIFO_DEPTH));
   assign push     = sel_found && !full;
   assign served   = push ? grant : '0;
   assign push_msg = make_note_msg(sel_on, 4'(CHANNEL),
                                   8'(BASE_NOTE) + 8'(sel_idx), 8'(VELOCITY));

   // A flag being pushed this cycle is retired first, so a new event on the same
   // button sets its own flag rather than cancelling one already queued.
   always_comb begin
      pend_on_nxt  = pend_on  & ~served;
      pend_off_nxt = pend_off & ~served;
      for (int unsigned i = 0; i < N_BTN; i++) begin
         if (on_evt[i]) begin
            if (pend_off_nxt[i]) pend_off_nxt[i] = 1'b0;
            else                 pend_on_nxt[i]  = 1'b1;
         end else if (off_evt[i]) begin
            if (pend_on_nxt[i])  pend_on_nxt[i]  = 1'b0;
            else                 pend_off_nxt[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_on  <= '0;
         pend_off <= '0;
      end else begin
         pend_on  <= pend_on_nxt;
         pend_off <= pend_off_nxt;
      end
   end

   assign pop = msg_valid && msg_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem   <= '{default: '0};
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem[tail] <= push_msg;
            tail      <= tail + PW'(1);
         end
         if (pop) head <= head + PW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (!push && pop) count <= count - CW'(1);
      end
   end

   assign head_msg   = mem[head];
   assign msg_valid  = (count != '0);
   assign msg_status = head_msg.status;
   assign msg_data1  = head_msg.data1;
   assign msg_data2  = head_msg.data2;
   assign busy       = msg_valid || (|pend_on) || (|pend_off);

endmodule
